inst_encoder: RTL
=================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning request-buffer depth in entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0000_0000, meaning write address after reset.
REQ-003 Ports SHALL be (clk and rst_n first):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  req_valid  in  1  encode request present
  req_ready  out  1  request can be accepted
  req_kind  in  4  0=R-type, 1=addi, 2=andi, 3=lw, 4=sw, 5=j, 6=beq, 7=bne, 8=nop, 9-15 invalid
  req_rs / req_rt / req_rd  in  5 each  register fields
  req_funct  in  6  R-type function field
  req_imm  in  16  I-type immediate
  req_target  in  26  jump target field
  base_load  in  1  load base_addr into write address
  base_addr  in  32  new write address
  mem_we  out  1  instruction-memory write request
  mem_addr  out  32  word byte-address
  mem_wdata  out  32  encoded instruction
  mem_ack  in  1  memory accepted current write
  err_invalid  out  1  one-cycle pulse on invalid req_kind
  busy  out  1  FIFO non-empty or write pending

Function
REQ-004 A request SHALL be accepted on a rising clk edge when req_valid and req_ready are both 1.
REQ-005 req_ready SHALL be 1 exactly when the FIFO holds fewer than FIFO_DEPTH entries; a same-cycle pop SHALL NOT raise req_ready.
REQ-006 Encoding SHALL be: R-type {6'b000000, rs, rt, rd, 5'b00000, funct}; addi/andi/lw/sw/beq/bne {opcode, rs, rt, imm} with opcodes 001000/001100/100011/101011/000100/000101; j {6'b000010, target}; nop 32'h0000_0000.
REQ-007 Fields unused by a kind SHALL be ignored; an R-type request with all-zero fields SHALL encode to 32'h0 (a nop).
REQ-008 An accepted invalid kind (9-15) SHALL NOT be enqueued, and err_invalid SHALL pulse 1 the following cycle.
REQ-009 Encoding SHALL occur before enqueue; the FIFO stores 32-bit words only.
REQ-010 Write FSM states: IDLE (mem_we=0) and WRITE (mem_we=1).
REQ-011 IDLE->WRITE when the FIFO is non-empty; WRITE->IDLE on mem_ack when the FIFO becomes empty; otherwise WRITE is held.
REQ-012 In WRITE, mem_addr and mem_wdata SHALL stay stable until mem_ack; mem_wdata SHALL be the FIFO head.
REQ-013 On mem_ack in WRITE, the head SHALL pop and mem_addr SHALL increment by 4 (modulo 2^32, FFFF_FFFC wraps to 0000_0000).
REQ-014 Back-to-back: with mem_ack held 1 and FIFO non-empty, one word SHALL be written per cycle.
REQ-015 Minimum latency: a request accepted at edge N SHALL appear on mem_we/mem_wdata after edge N+1.
REQ-016 Simultaneous push and pop with the FIFO full SHALL pop the head and SHALL NOT accept the request, per REQ-005.
REQ-017 base_load SHALL take effect only when busy=0; when busy=1 it SHALL be ignored without error.
REQ-018 mem_ack outside WRITE SHALL be ignored.
REQ-019 busy SHALL be 1 whenever FIFO count > 0 or state = WRITE.

Reset
REQ-020 While rst_n=0, asynchronously: state=IDLE, FIFO empty, mem_addr=RESET_ADDR, mem_we=0, mem_wdata=0, err_invalid=0, busy=0, req_ready=1.
REQ-021 Reset mid-write SHALL discard all queued words and the pending write; no mem_we SHALL appear until a new request is accepted.

Structure
REQ-022 The opcode constants (shared with the opcode decoder) and the req_kind encodings SHALL reside in shared package mips_pkg.
REQ-023 The buffer SHALL be one sub-module, enc_fifo (synchronous FIFO, parameter width 32 and FIFO_DEPTH).

Verification
REQ-024 addi rs=8 rt=9 imm=5 -> one write: mem_addr 0x0, mem_wdata 0x21090005.
REQ-025 The sequence lw(29,8,4), sw(29,8,4), j(0x10), beq(1,2,0xFFFF), R(9,10,8,0x20) with mem_ack=1 -> words 0x8FA80004, 0xAFA80004, 0x08000010, 0x1022FFFF, 0x012A4020 at addresses 0x0, 0x4, 0x8, 0xC, 0x10 on consecutive cycles.
REQ-026 mem_ack=0 and 5 valid requests -> exactly 4 accepted, then req_ready=0; mem_addr/mem_wdata stable; after ack, order preserved.
REQ-027 req_kind=12 -> no write, err_invalid high exactly 1 cycle, busy stays 0.
REQ-028 base_load with base_addr=0xFFFFFFFC while idle, then 2 nops -> writes of 0x0 at addresses 0xFFFFFFFC and 0x00000000.
REQ-029 rst_n dropped with 3 words queued and mem_ack=0 -> mem_we=0 immediately, mem_addr=RESET_ADDR, and no write follows release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: request kinds, primary opcodes and the
// instruction encoder used ahead of the request buffer.
package mips_pkg;

    typedef enum logic [3:0] {
        KIND_RTYPE = 4'd0,
        KIND_ADDI  = 4'd1,
        KIND_ANDI  = 4'd2,
        KIND_LW    = 4'd3,
        KIND_SW    = 4'd4,
        KIND_J     = 4'd5,
        KIND_BEQ   = 4'd6,
        KIND_BNE   = 4'd7,
        KIND_NOP   = 4'd8
    } req_kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic {
        WR_IDLE,
        WR_WRITE
    } wr_state_e;

    function automatic logic kind_is_valid(input logic [3:0] kind);
        return kind <= 4'(KIND_NOP);
    endfunction

    // Fields a kind does not use never reach the encoded word.
    function automatic logic [31:0] encode_inst(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = '0;
        case (kind)
            KIND_RTYPE: w = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
            KIND_ADDI:  w = {OP_ADDI, rs, rt, imm};
            KIND_ANDI:  w = {OP_ANDI, rs, rt, imm};
            KIND_LW:    w = {OP_LW, rs, rt, imm};
            KIND_SW:    w = {OP_SW, rs, rt, imm};
            KIND_J:     w = {OP_J, target};
            KIND_BEQ:   w = {OP_BEQ, rs, rt, imm};
            KIND_BNE:   w = {OP_BNE, rs, rt, imm};
            default:    w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO holding encoded instruction words; count is registered so
// fullness reflects only completed pushes and pops.
module enc_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/inst_encoder.sv
// Encodes instruction requests into 32-bit words, buffers them and writes them
// to consecutive instruction-memory addresses through an IDLE/WRITE handshake.
module inst_encoder
    import mips_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [5:0]  req_funct,
    input  logic [15:0] req_imm,
    input  logic [25:0] req_target,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        err_invalid,
    output logic        busy
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e   state_q, state_d;
    logic [31:0] addr_q;
    logic        err_q;
    logic        accept, kind_ok, push, pop;
    logic        fifo_full, fifo_empty;
    logic [31:0] enc_word, head_word;
    logic [CW-1:0] fifo_count;

    assign accept   = req_valid && req_ready;
    assign kind_ok  = kind_is_valid(req_kind);
    assign push     = accept && kind_ok;
    assign pop      = (state_q == WR_WRITE) && mem_ack;
    assign enc_word = encode_inst(req_kind, req_rs, req_rt, req_rd,
                                  req_funct, req_imm, req_target);

    enc_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (enc_word),
        .pop_i   (pop),
        .data_o  (head_word),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req_ready   = !fifo_full;
    assign busy        = !fifo_empty || (state_q == WR_WRITE);
    assign mem_addr    = addr_q;
    assign err_invalid = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WR_IDLE;
        else        state_q <= state_d;
    end

    // Leave WRITE only when this ack drains the last word and nothing refills it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE:  if (!fifo_empty) state_d = WR_WRITE;
            WR_WRITE: if (mem_ack && (fifo_count == CW'(1)) && !push) state_d = WR_IDLE;
            default:  state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state_q == WR_WRITE) begin
            mem_we    = 1'b1;
            mem_wdata = head_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= RESET_ADDR;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && !kind_ok;
            if (pop)                    addr_q <= addr_q + 32'd4;
            else if (base_load && !busy) addr_q <= base_addr;
        end
    end

endmodule
